// File: rtl/riscv_lsu.sv
// RV32I load/store unit: one outstanding access, IDLE -> ACCESS -> RESP, with ack timeout.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses become error responses.
module riscv_lsu #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   output logic        mem_re,
   output logic        mem_we,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [1:0]  dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // valid and its payload stay stable until that edge, and ready never waits on valid.
   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic          lat_we;
   logic [2:0]    lat_f3;
   logic [1:0]    lat_off;
   logic          req_bad;
   logic [3:0]    req_be;
   logic [31:0]   req_wrep;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [31:0]   ld_data;

   assign dbg_state = state;
   assign cnt_inc   = cnt + CW'(1);

   always_comb begin
      req_bad = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_we && req_funct3[2]);
`ifdef MISALIGN_TRAP_EN
      if ((req_funct3[1:0] == 2'b01) && req_addr[0])
         req_bad = 1'b1;
      if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
         req_bad = 1'b1;
`endif
   end

   always_comb begin
      req_be   = 4'b1111;
      req_wrep = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            req_be   = 4'b0001 << req_addr[1:0];
            req_wrep = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            req_be   = 4'b0011 << {req_addr[1], 1'b0};
            req_wrep = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Extraction uses the latched offset/width, so the request bus is free during ACCESS.
   always_comb begin
      ld_byte = mem_rdata[7:0];
      case (lat_off)
         2'd1:    ld_byte = mem_rdata[15:8];
         2'd2:    ld_byte = mem_rdata[23:16];
         2'd3:    ld_byte = mem_rdata[31:24];
         default: ;
      endcase
      ld_half = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (lat_f3)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         lat_we     <= 1'b0;
         lat_f3     <= 3'b000;
         lat_off    <= 2'b00;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'd0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
         mem_be     <= 4'b0000;
         mem_re     <= 1'b0;
         mem_we     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_we    <= req_we;
                  lat_f3    <= req_funct3;
                  lat_off   <= req_addr[1:0];
                  req_ready <= 1'b0;
                  if (req_bad) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'd0;
                  end else begin
                     state     <= ACCESS;
                     cnt       <= '0;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_be    <= req_be;
                     mem_wdata <= req_we ? req_wrep : 32'd0;
                     mem_re    <= !req_we;
                     mem_we    <= req_we;
                  end
               end
            end
            ACCESS: begin
               // Ack is tested first so it wins over a timeout on the same edge.
               if (mem_ack) begin
                  state      <= RESP;
                  mem_re     <= 1'b0;
                  mem_we     <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= lat_we ? 32'd0 : ld_data;
               end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
                  state      <= RESP;
                  mem_re     <= 1'b0;
                  mem_we     <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= 32'd0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: a transaction-level model predicts every cycle's outputs.
module tb_riscv_lsu;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        mem_re, mem_we, mem_ack;
   logic [1:0]  dbg_state;

   riscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   typedef enum int {P_IDLE, P_ACCESS, P_RESP} phase_t;

   typedef struct {
      logic        bad;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] ld;
      logic [31:0] rd;
      logic        err;
   } exp_t;

   phase_t      phase = P_IDLE;
   exp_t        e;
   logic        chk_en = 1'b0;
   int          n_vec = 0;
   int          n_fail = 0;
   int          cap_strobes;
   logic [3:0]  cap_be;
   logic [31:0] cap_addr, cap_wd, cap_rdata;
   logic        cap_we, cap_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected access derived from size/offset arithmetic on the request.
   function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata);
      exp_t        m;
      int          size, off;
      logic [31:0] mask, v;
      size   = 1 << f3[1:0];
      m.we   = we;
      m.addr = addr & 32'hFFFF_FFFC;
      m.bad  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
`ifdef MISALIGN_TRAP_EN
      if (!m.bad && (int'(addr[1:0]) % size) != 0) m.bad = 1'b1;
`endif
      off  = (int'(addr[1:0]) / size) * size;
      m.be = 4'(((1 << size) - 1) << off);
      mask = (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      if (size == 1)      m.wd = (wdata & 32'hFF) * 32'h0101_0101;
      else if (size == 2) m.wd = (wdata & 32'hFFFF) * 32'h0001_0001;
      else                m.wd = wdata;
      v = (rdata >> (8 * off)) & mask;
      if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
      m.ld  = v;
      m.rd  = 32'd0;
      m.err = 1'b0;
      return m;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready", {31'd0, req_ready}, {31'd0, phase == P_IDLE});
         if (mem_re || mem_we) cap_strobes++;
         case (phase)
            P_IDLE: begin
               chk("idle_re", {31'd0, mem_re}, 32'd0);
               chk("idle_we", {31'd0, mem_we}, 32'd0);
               chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
            end
            P_ACCESS: begin
               chk("acc_re", {31'd0, mem_re}, {31'd0, !e.we});
               chk("acc_we", {31'd0, mem_we}, {31'd0, e.we});
               chk("acc_addr", mem_addr, e.addr);
               chk("acc_be", {28'd0, mem_be}, {28'd0, e.be});
               if (e.we) chk("acc_wdata", mem_wdata, e.wd);
               chk("acc_resp_valid", {31'd0, resp_valid}, 32'd0);
               cap_be = mem_be; cap_addr = mem_addr; cap_wd = mem_wdata; cap_we = mem_we;
            end
            default: begin
               chk("resp_re", {31'd0, mem_re}, 32'd0);
               chk("resp_we", {31'd0, mem_we}, 32'd0);
               chk("resp_valid", {31'd0, resp_valid}, 32'd1);
               chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
               chk("resp_rdata", resp_rdata, e.rd);
               cap_rdata = resp_rdata; cap_err = resp_err;
            end
         endcase
      end
   end

   // ack_at < 0 means mem_ack never comes; poke drives a request during the RESP handshake.
   task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int ack_at, input int resp_wait, input logic poke);
      bit acked;
      e = model(we, f3, addr, wdata, rdata);
      cap_strobes = 0;
      acked = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'b010;
      if (e.bad) begin
         e.err = 1'b1; e.rd = 32'd0;
         phase = P_RESP;
      end else begin
         phase = P_ACCESS;
         for (int i = 0; i < TO; i++) begin
            if (i == ack_at) begin mem_ack = 1'b1; mem_rdata = rdata; acked = 1'b1; end
            else mem_rdata = $urandom;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (acked) break;
         end
         e.err = !acked;
         e.rd  = (acked && !we) ? e.ld : 32'd0;
         phase = P_RESP;
      end
      repeat (resp_wait) begin
         mem_ack = 1'b1; mem_rdata = $urandom;
         @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      resp_ready = 1'b1;
      if (poke) begin
         req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
      end
      @(posedge clk); #1;
      resp_ready = 1'b0; req_valid = 1'b0;
      phase = P_IDLE;
   endtask

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
      mem_rdata = 32'd0; mem_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1; chk_en = 1'b1;

      do_txn(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0, 0, 1'b0);
      chk("pin_lb_be", {28'd0, cap_be}, 32'h0000_0008);
      chk("pin_lb_rdata", cap_rdata, 32'hFFFF_FF80);
      chk("pin_lb_err", {31'd0, cap_err}, 32'd0);

      do_txn(1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD, 32'd0, 0, 2, 1'b1);
      chk("pin_sh_we", {31'd0, cap_we}, 32'd1);
      chk("pin_sh_be", {28'd0, cap_be}, 32'h0000_000C);
      chk("pin_sh_wdata", cap_wd, 32'hABCD_ABCD);
      chk("pin_sh_addr", cap_addr, 32'h0000_0020);
      chk("pin_sh_rdata", cap_rdata, 32'd0);

      do_txn(1'b0, 3'b010, 32'h0000_0200, 32'd0, 32'd0, -1, 1, 1'b0);
      chk("pin_to_strobes", cap_strobes, 32'd16);
      chk("pin_to_err", {31'd0, cap_err}, 32'd1);
      chk("pin_to_rdata", cap_rdata, 32'd0);

      do_txn(1'b0, 3'b011, 32'h0000_0010, 32'd0, 32'd0, 0, 0, 1'b0);
      chk("pin_f3_011_strobes", cap_strobes, 32'd0);
      chk("pin_f3_011_err", {31'd0, cap_err}, 32'd1);

      do_txn(1'b0, 3'b101, 32'h0000_0041, 32'd0, 32'h8001_7777, 1, 0, 1'b0);
`ifdef MISALIGN_TRAP_EN
      chk("pin_lhu_mis_err", {31'd0, cap_err}, 32'd1);
      chk("pin_lhu_mis_strobes", cap_strobes, 32'd0);
`else
      chk("pin_lhu_mis_rdata", cap_rdata, 32'h0000_7777);
      chk("pin_lhu_mis_err", {31'd0, cap_err}, 32'd0);
`endif

      do_txn(1'b0, 3'b001, 32'h0000_0046, 32'd0, 32'h8001_F234, 2, 0, 1'b0);
      chk("pin_lh_rdata", cap_rdata, 32'hFFFF_8001);
      do_txn(1'b0, 3'b100, 32'h0000_0005, 32'd0, 32'h1234_5678, 0, 1, 1'b0);
      chk("pin_lbu_rdata", cap_rdata, 32'h0000_0056);
      do_txn(1'b1, 3'b000, 32'h0000_0007, 32'h0000_00A5, 32'd0, 1, 0, 1'b0);
      chk("pin_sb_wdata", cap_wd, 32'hA5A5_A5A5);
      do_txn(1'b1, 3'b010, 32'h0000_001C, 32'hDEAD_BEEF, 32'd0, 0, 0, 1'b1);

      do_txn(1'b0, 3'b010, 32'h0000_0080, 32'd0, 32'hCAFE_F00D, TO - 1, 0, 1'b0);
      chk("pin_coinc_err", {31'd0, cap_err}, 32'd0);
      chk("pin_coinc_rdata", cap_rdata, 32'hCAFE_F00D);
      chk("pin_coinc_strobes", cap_strobes, 32'd16);

      do_txn(1'b1, 3'b100, 32'h0000_0030, 32'h0000_0011, 32'd0, 0, 0, 1'b0);
      do_txn(1'b0, 3'b110, 32'h0000_0034, 32'd0, 32'd0, 0, 1, 1'b0);
      do_txn(1'b0, 3'b111, 32'h0000_0038, 32'd0, 32'd0, 0, 0, 1'b0);
      do_txn(1'b1, 3'b011, 32'h0000_003C, 32'h0000_0022, 32'd0, 0, 0, 1'b0);
      do_txn(1'b0, 3'b010, 32'h0000_0013, 32'd0, 32'h1122_3344, 1, 0, 1'b0);

      // Reset in the middle of an access.
      e = model(1'b0, 3'b010, 32'h0000_0300, 32'd0, 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0300;
      @(posedge clk); #1;
      req_valid = 1'b0;
      phase = P_ACCESS;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      phase = P_IDLE;
      #1;
      chk("async_rst_mem_re", {31'd0, mem_re}, 32'd0);
      chk("async_rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("async_rst_mem_addr", mem_addr, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      do_txn(1'b0, 3'b010, 32'h0000_0304, 32'd0, 32'h5A5A_0F0F, 1, 0, 1'b0);
      chk("pin_post_rst_lw", cap_rdata, 32'h5A5A_0F0F);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: number of ACCESS cycles without mem_ack before the access is aborted.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  core requests a load/store.
REQ-005 SHALL have port req_ready  output  1  LSU can accept a request.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32I width/sign code.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  response available.
REQ-011 SHALL have port resp_ready  input  1  core takes the response.
REQ-012 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  access failed.
REQ-014 SHALL have port mem_addr  output  32  word address, {addr[31:2],2'b00}.
REQ-015 SHALL have port mem_wdata  output  32  lane-replicated store data.
REQ-016 SHALL have port mem_be  output  4  byte enables.
REQ-017 SHALL have ports mem_re and mem_we  output  1  each: read/write strobes.
REQ-018 SHALL have port mem_rdata  input  32  memory read word.
REQ-019 SHALL have port mem_ack  input  1  memory completes the access.

Function
REQ-020 SHALL implement an FSM with states IDLE, ACCESS and RESP.
REQ-021 In IDLE, req_ready SHALL be 1; in ACCESS and RESP it SHALL be 0.
REQ-022 An accepted request (IDLE, req_valid=1) SHALL latch we, funct3, addr and wdata.
REQ-023 A valid accepted request SHALL move the FSM to ACCESS on the next edge.
REQ-024 An invalid request SHALL go directly to RESP with resp_err=1 and SHALL raise no memory strobe.
REQ-025 A request is invalid when funct3 is 011, 110 or 111, or when it is a store with funct3[2]=1.
REQ-026 In ACCESS, exactly one of mem_re/mem_we SHALL be 1, held with stable mem_addr, mem_be and mem_wdata until mem_ack or timeout.
REQ-027 Byte enables SHALL be: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011<<{addr[1],1'b0}; word -> 4'b1111.
REQ-028 mem_wdata SHALL be: SB -> byte replicated x4; SH -> halfword replicated x2; SW -> unchanged.
REQ-029 Load extraction: LB/LBU select byte addr[1:0], LH/LHU select half addr[1], then sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes the word.
REQ-030 On mem_ack in ACCESS, the FSM SHALL register the result, drop the strobes next edge and enter RESP; minimum latency is accept -> resp_valid in 2 cycles.
REQ-031 A cycle counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack.
REQ-032 When the counter reaches TIMEOUT_CYCLES, the FSM SHALL drop the strobes and enter RESP with resp_err=1 and resp_rdata=0.
REQ-033 If ack and timeout coincide, ack SHALL win.
REQ-034 In RESP, resp_valid SHALL be 1 with stable data until resp_ready=1; then the FSM SHALL go to IDLE.
REQ-035 The LSU SHALL NOT accept a new request in the same cycle as the RESP handshake.
REQ-036 mem_ack outside ACCESS SHALL be ignored.

Reset
REQ-037 While reset=0, the FSM SHALL be IDLE and the counter 0.
REQ-038 While reset=0, outputs SHALL be: req_ready=1; resp_valid, resp_err, mem_re, mem_we=0; resp_rdata, mem_addr, mem_wdata=0; mem_be=4'b0000.
REQ-039 Reset asserted mid-ACCESS SHALL drop the strobes immediately (asynchronously); the in-flight access is discarded.

Configuration
REQ-040 Macro MISALIGN_TRAP_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL be invalid (go to RESP with resp_err=1, no strobe).
REQ-041 Macro MISALIGN_TRAP_EN undefined: misaligned low address bits SHALL be ignored (half uses addr[1], word uses the aligned word) and no error is raised.

Verification
REQ-042 LB addr 0x103, mem_rdata 0x80FF_0000, ack after 1 cycle -> mem_be 4'b1000, resp_rdata 0xFFFF_FF80, resp_err 0.
REQ-043 SH addr 0x22, wdata 0x1234_ABCD -> mem_we=1, mem_be 4'b1100, mem_wdata 0xABCD_ABCD, mem_addr 0x20; resp_rdata 0.
REQ-044 LW with mem_ack held 0 and TIMEOUT_CYCLES=16 -> strobe held 16 cycles then dropped; resp_err 1, resp_rdata 0.
REQ-045 funct3 011 load -> no strobe, resp_valid 1 cycle after accept, resp_err 1.
REQ-046 LHU addr 0x41 with MISALIGN_TRAP_EN defined -> resp_err 1, no strobe; with it undefined and mem_rdata 0x8001_7777 -> resp_rdata 0x0000_7777.
REQ-047 Reset=0 mid-ACCESS, then released -> mem_re drops at once; req_ready 1 and resp_valid 0 after release; a following LW completes normally.
